// File: rtl/emul_pkg.sv
// Shared types and constants for the emul_vec_pipe bf16 x bf16 -> fp32 multiplier.
// Optional feature macro used elsewhere in this slice: EMUL_FLAGS_EN.
package emul_pkg;

  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} emul_state_t;

  // Operand / product class decided in the first pipeline stage.
  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} op_class_t;

  typedef struct packed {
    logic                  sign;
    logic [BF16_EXP_W-1:0] exp;
    logic [BF16_MAN_W-1:0] man;
  } bf16_t;

  // Subnormals fold into zero: this datapath flushes them on input.
  function automatic op_class_t classify(input bf16_t x);
    if (x.exp == '0)       return CLS_ZERO;
    else if (x.exp == '1)  return (x.man == '0) ? CLS_INF : CLS_NAN;
    else                   return CLS_NORM;
  endfunction

endpackage

// File: rtl/bf16_mul_lane.sv
// One lane of the bf16 x bf16 -> fp32 multiplier: 3 enable-gated stages
// (unpack/special-case, 8x8 mantissa multiply, normalise/pack).
// With EMUL_FLAGS_EN defined the lane also reports {nan, ovf, ftz}.
module bf16_mul_lane
  import emul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] res
`ifdef EMUL_FLAGS_EN
  ,
  output logic [2:0]  flags
`endif
);

  localparam logic signed [9:0] BIAS10 = 10'(FP32_BIAS);

  bf16_t     op_a, op_b;
  op_class_t cls_a, cls_b, s1_cls_d;
  logic signed [9:0] s1_exp_d;

  assign op_a  = bf16_t'(a);
  assign op_b  = bf16_t'(b);
  assign cls_a = classify(op_a);
  assign cls_b = classify(op_b);
  // Biased sum can range from -125 to 381, so 10 signed bits hold it.
  assign s1_exp_d = $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp}) - BIAS10;

  // Combine the two operand classes into the product class.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    s1_cls_d = CLS_NORM;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
        (cls_a == CLS_ZERO && cls_b == CLS_INF))
      s1_cls_d = CLS_NAN;
    else if (cls_a == CLS_INF || cls_b == CLS_INF)
      s1_cls_d = CLS_INF;
    else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)
      s1_cls_d = CLS_ZERO;
  end

  logic              s1_sign;
  op_class_t         s1_cls;
  logic signed [9:0] s1_exp;
  logic [7:0]        s1_ma, s1_mb;

  // Stage 1: register sign, class, exponent sum and mantissas with hidden bit.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, so result_tdata reads 0 straight after reset.
    if (rst) begin
      s1_sign <= 1'b0;
      s1_cls  <= CLS_NORM;
      s1_exp  <= '0;
      s1_ma   <= '0;
      s1_mb   <= '0;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
      s1_sign <= op_a.sign ^ op_b.sign;
      s1_cls  <= s1_cls_d;
      s1_exp  <= s1_exp_d;
      s1_ma   <= {1'b1, op_a.man};
      s1_mb   <= {1'b1, op_b.man};
    end
  end

  logic              s2_sign;
  op_class_t         s2_cls;
  logic signed [9:0] s2_exp;
  logic [15:0]       s2_prod;

  // Stage 2: 8x8 mantissa multiply; product lies in [1,4) as a 2.14 value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sign <= 1'b0;
      s2_cls  <= CLS_NORM;
      s2_exp  <= '0;
      s2_prod <= '0;
    end else if (en) begin
      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_exp  <= s1_exp;
      s2_prod <= {8'b0, s1_ma} * {8'b0, s1_mb};
    end
  end

  logic signed [9:0]       n_exp;
  logic [FP32_MAN_W-1:0]   n_frac;
  logic [31:0]             res_d;
`ifdef EMUL_FLAGS_EN
  logic [2:0]              flags_d;
`endif

  // A product >= 2 shifts right by one and bumps the exponent; 16 bits fit in 24 exactly.
  assign n_exp  = s2_exp + $signed({9'b0, s2_prod[15]});
  assign n_frac = s2_prod[15] ? {s2_prod[14:0], 8'b0} : {s2_prod[13:0], 9'b0};

  // Normalise and pack, applying the special-value and range rules.
  always_comb begin
    res_d = {s2_sign, n_exp[FP32_EXP_W-1:0], n_frac};
`ifdef EMUL_FLAGS_EN
    flags_d = 3'b000;
`endif
    unique case (s2_cls)
      CLS_NAN: begin
        res_d = FP32_QNAN;
`ifdef EMUL_FLAGS_EN
        flags_d = 3'b100;
`endif
      end
      CLS_INF:  res_d = {s2_sign, 8'hFF, 23'b0};
      CLS_ZERO: res_d = {s2_sign, 31'b0};
      default: begin
        if (n_exp < 10'sd1) begin
          res_d = {s2_sign, 31'b0};
`ifdef EMUL_FLAGS_EN
          flags_d = 3'b001;
`endif
        end else if (n_exp > 10'sd254) begin
          res_d = {s2_sign, 8'hFF, 23'b0};
`ifdef EMUL_FLAGS_EN
          flags_d = 3'b010;
`endif
        end
      end
    endcase
  end

  // Stage 3: output register, drives result_tdata directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
`ifdef EMUL_FLAGS_EN
      flags <= '0;
`endif
    end else if (en) begin
      res <= res_d;
`ifdef EMUL_FLAGS_EN
      flags <= flags_d;
`endif
    end
  end

endmodule

// File: rtl/emul_vec_pipe.sv
// Job-controlled N-lane bf16 x bf16 -> fp32 multiplier with valid/ready backpressure.
// Top owns the job FSM, beat counter, valid/last pipeline and handshakes; lanes hold the math.
// With EMUL_FLAGS_EN defined, adds sticky flags[2:0] = {nan, ovf, ftz}, valid while done=1.
module emul_vec_pipe
  import emul_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  input  logic                  a_tvalid,
  input  logic [LANES*16-1:0]   a_tdata,
  input  logic                  b_tvalid,
  input  logic [LANES*16-1:0]   b_tdata,
  output logic                  in_tready,
  output logic                  result_tvalid,
  input  logic                  result_tready,
  output logic [LANES*32-1:0]   result_tdata,
  output logic                  result_tlast
`ifdef EMUL_FLAGS_EN
  ,
  output logic [2:0]            flags
`endif
);

  emul_state_t      state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] in_cnt;
  logic             en;
  logic             in_fire;
  logic             start_fire;
  logic             in_is_last;
  logic             out_last_fire;

  // Whole pipe advances together whenever the output slot is free or being drained.
  assign en            = !result_tvalid || result_tready;
  assign in_tready     = en && (state == RUN);
  assign in_fire       = a_tvalid && b_tvalid && in_tready;
  assign start_fire    = start && (state == IDLE);
  assign in_is_last    = (in_cnt + LEN_W'(1)) == len_q;
  assign out_last_fire = result_tvalid && result_tready && result_tlast;

  // Job FSM with registered busy/done; start is only honoured in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      len_q  <= '0;
      in_cnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_fire) begin
            len_q  <= len;
            in_cnt <= '0;
            busy   <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (in_fire) begin
            in_cnt <= in_cnt + LEN_W'(1);
            if (in_is_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_last_fire) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic s1_valid, s1_last, s2_valid, s2_last;

  // Valid and last tags travel alongside the lane data, gated by the same enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_last       <= 1'b0;
      s2_valid      <= 1'b0;
      s2_last       <= 1'b0;
      result_tvalid <= 1'b0;
      result_tlast  <= 1'b0;
    end else if (en) begin
      s1_valid      <= in_fire;
      s1_last       <= in_fire && in_is_last;
      s2_valid      <= s1_valid;
      s2_last       <= s1_last;
      result_tvalid <= s2_valid;
      result_tlast  <= s2_last;
    end
  end

`ifdef EMUL_FLAGS_EN
  logic [LANES-1:0][2:0] lane_flags;
  logic [2:0]            beat_flags;

  // Any lane raising a flag marks the beat.
  always_comb begin
    beat_flags = 3'b000;
    for (int i = 0; i < LANES; i++) beat_flags = beat_flags | lane_flags[i];
  end

  // Sticky over accepted result beats, cleared when a new job starts.
  always_ff @(posedge clk) begin
    if (rst)                                  flags <= 3'b000;
    else if (start_fire)                      flags <= 3'b000;
    else if (result_tvalid && result_tready)  flags <= flags | beat_flags;
  end
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bf16_mul_lane u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (a_tdata[16*i +: 16]),
      .b   (b_tdata[16*i +: 16]),
      .res (result_tdata[32*i +: 32])
`ifdef EMUL_FLAGS_EN
      ,
      .flags (lane_flags[i])
`endif
    );
  end

endmodule

// File: tb/tb_emul_vec_pipe.sv
// Scoreboard bench for emul_vec_pipe: stimulus pushes expected beats, a negedge monitor
// pops and compares. Checks flags too when built with EMUL_FLAGS_EN.
module tb_emul_vec_pipe;

  localparam int LANES = 4;
  localparam int LEN_W = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [LEN_W-1:0]     len;
  logic                 busy, done;
  logic                 a_tvalid, b_tvalid;
  logic [LANES*16-1:0]  a_tdata, b_tdata;
  logic                 in_tready;
  logic                 result_tvalid;
  logic                 result_tready;
  logic [LANES*32-1:0]  result_tdata;
  logic                 result_tlast;
`ifdef EMUL_FLAGS_EN
  logic [2:0]           flags;
`endif

  emul_vec_pipe #(.LANES(LANES), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .len           (len),
    .busy          (busy),
    .done          (done),
    .a_tvalid      (a_tvalid),
    .a_tdata       (a_tdata),
    .b_tvalid      (b_tvalid),
    .b_tdata       (b_tdata),
    .in_tready     (in_tready),
    .result_tvalid (result_tvalid),
    .result_tready (result_tready),
    .result_tdata  (result_tdata),
    .result_tlast  (result_tlast)
`ifdef EMUL_FLAGS_EN
    ,
    .flags         (flags)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_beat_t;

  exp_beat_t    sb[$];
  logic [2:0]   job_flags;
  bit           mon_en = 1'b0;
  bit           pend_done = 1'b0;
  bit           held_valid = 1'b0;
  logic [127:0] held_data;
  logic         held_last;
  int           tready_mode = 0;  // 0 always ready, 1 random 50%, 2 never ready

  // Reference multiply from the arithmetic rules: returns {flags, fp32}.
  function automatic logic [34:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int sa, sb_, ea, eb, ma, mb, p, k, be, frac;
    bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    sa = a[15]; ea = a[14:7]; ma = a[6:0];
    sb_ = b[15]; eb = b[14:7]; mb = b[6:0];
    nan_a = (ea == 255) && (ma != 0); inf_a = (ea == 255) && (ma == 0); zero_a = (ea == 0);
    nan_b = (eb == 255) && (mb != 0); inf_b = (eb == 255) && (mb == 0); zero_b = (eb == 0);
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b))
      return {3'b100, 32'h7FC00000};
    if (inf_a || inf_b)
      return {3'b000, 1'(sa ^ sb_), 8'hFF, 23'd0};
    if (zero_a || zero_b)
      return {3'b000, 1'(sa ^ sb_), 31'd0};
    p = (128 + ma) * (128 + mb);
    k = 0;
    for (int j = 0; j < 16; j++) if (((p >> j) & 1) == 1) k = j;
    be = ea + eb - 127 + (k - 14);
    if (be < 1)   return {3'b001, 1'(sa ^ sb_), 31'd0};
    if (be > 254) return {3'b010, 1'(sa ^ sb_), 8'hFF, 23'd0};
    frac = (p << (23 - k)) & 32'h007FFFFF;
    return {3'b000, 1'(sa ^ sb_), 8'(be), 23'(frac)};
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [15:0] v;
    int r;
    r = $urandom_range(0, 15);
    v = 16'($urandom);
    case (r)
      0: v[14:0] = 15'd0;
      1: v[14:0] = {8'hFF, 7'd0};
      2: v[14:7] = 8'hFF;
      3: v[14:7] = 8'h00;
      4: v[14:7] = 8'($urandom_range(8'hE0, 8'hFE));
      5: v[14:7] = 8'($urandom_range(1, 8'h20));
      default: v[14:7] = 8'($urandom_range(8'h60, 8'hA0));
    endcase
    return v;
  endfunction

  // Ready driver, changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (tready_mode)
      0: result_tready = 1'b1;
      1: result_tready = 1'($urandom_range(0, 1));
      default: result_tready = 1'b0;
    endcase
  end

  // Monitor: done timing, stall stability, in-order beat comparison.
  always @(negedge clk) begin
    bit exp_d;
    exp_exp: begin end
    if (mon_en && !rst) begin
      exp_d = pend_done;
      pend_done = 1'b0;
      if (done || exp_d) check("done_pulse", 128'(done), 128'(exp_d));
`ifdef EMUL_FLAGS_EN
      if (done && exp_d) check("flags", 128'(flags), 128'(job_flags));
`endif
      if (held_valid) begin
        check("stall_valid", 128'(result_tvalid), 128'(1'b1));
        check("stall_data", result_tdata, held_data);
        check("stall_last", 128'(result_tlast), 128'(held_last));
      end
      held_valid = result_tvalid && !result_tready;
      held_data  = result_tdata;
      held_last  = result_tlast;
      if (result_tvalid && result_tready) begin
        if (sb.size() == 0) begin
          check("beat_unexpected", 128'(1'b1), 128'(1'b0));
        end else begin
          exp_beat_t e;
          e = sb.pop_front();
          check("beat_data", result_tdata, e.data);
          check("beat_last", 128'(result_tlast), 128'(e.last));
          if (result_tlast) pend_done = 1'b1;
        end
      end
    end
  end

  task automatic start_job(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    job_flags = 3'b000;
    if (n == 0) pend_done = 1'b1;
    check("busy_after_start", 128'(busy), 128'(1'b1));
  endtask

  // Offer one beat until accepted (bounded); returns with the beat already accepted.
  task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input bit jitter);
    bit acc;
    int cyc;
    acc = 1'b0;
    cyc = 0;
    a_tdata = a;
    b_tdata = b;
    while (!acc && cyc < 500) begin
      a_tvalid = jitter ? ($urandom_range(0, 3) != 0) : 1'b1;
      b_tvalid = jitter ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = a_tvalid && b_tvalid && in_tready;
      @(posedge clk); #1;
      cyc++;
    end
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    if (!acc) check("accept_timeout", 128'(1'b0), 128'(1'b1));
  endtask

  function automatic exp_beat_t model_beat(input logic [63:0] a, input logic [63:0] b, input bit last);
    exp_beat_t e;
    logic [34:0] r;
    e.data = '0;
    e.last = last;
    for (int i = 0; i < LANES; i++) begin
      r = ref_mul(a[16*i +: 16], b[16*i +: 16]);
      e.data[32*i +: 32] = r[31:0];
    end
    return e;
  endfunction

  function automatic logic [2:0] model_flags(input logic [63:0] a, input logic [63:0] b);
    logic [2:0]  f;
    logic [34:0] r;
    f = 3'b000;
    for (int i = 0; i < LANES; i++) begin
      r = ref_mul(a[16*i +: 16], b[16*i +: 16]);
      f = f | r[34:32];
    end
    return f;
  endfunction

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) check("done_timeout", 128'(1'b0), 128'(1'b1));
    @(posedge clk); #1;
    check("busy_idle", 128'(busy), 128'(1'b0));
    check("sb_empty", 128'(sb.size()), 128'(0));
  endtask

  task automatic run_random_job(input int n, input bit jitter);
    logic [63:0] a, b;
    start_job(n);
    for (int i = 1; i <= n; i++) begin
      for (int l = 0; l < LANES; l++) begin
        a[16*l +: 16] = rand_bf16();
        b[16*l +: 16] = rand_bf16();
      end
      sb.push_back(model_beat(a, b, i == n));
      job_flags = job_flags | model_flags(a, b);
      send_beat(a, b, jitter);
    end
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'(1'b0));
    check({tag, "_done"}, 128'(done), 128'(1'b0));
    check({tag, "_in_tready"}, 128'(in_tready), 128'(1'b0));
    check({tag, "_tvalid"}, 128'(result_tvalid), 128'(1'b0));
    check({tag, "_tlast"}, 128'(result_tlast), 128'(1'b0));
    check({tag, "_tdata"}, result_tdata, 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_beat_t e;
    logic [63:0] a, b;
    rst = 1'b1; start = 1'b0; len = '0;
    a_tvalid = 1'b0; b_tvalid = 1'b0; a_tdata = '0; b_tdata = '0;
    result_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // 1: 1.0 x 2.0 on all lanes, single beat.
    start_job(1);
    e.data = {4{32'h40000000}}; e.last = 1'b1;
    sb.push_back(e);
    send_beat({4{16'h3F80}}, {4{16'h4000}}, 1'b0);
    wait_done();

    // 2: sign, NaN from inf x 0, overflow.
    start_job(1);
    e.data = {32'h7F800000, 32'h7FC00000, 32'hC0100000, 32'h40100000}; e.last = 1'b1;
    sb.push_back(e);
    job_flags = 3'b110;
    send_beat({16'h7F00, 16'h7F80, 16'hBFC0, 16'hBFC0},
              {16'h7F00, 16'h0000, 16'h3FC0, 16'hBFC0}, 1'b0);
    wait_done();

    // 3: eight random beats under random backpressure and input gaps.
    tready_mode = 1;
    run_random_job(8, 1'b1);

    // 4: a-only offered for 5 cycles must not be consumed; then latency of the joined beat.
    tready_mode = 0;
    @(posedge clk); #1;
    start_job(2);
    a = {4{16'h4040}}; b = {4{16'h3F80}};
    a_tdata = a; b_tdata = b;
    a_tvalid = 1'b1; b_tvalid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("join_ready_a_only", 128'(in_tready), 128'(1'b1));
      @(posedge clk); #1;
    end
    b_tvalid = 1'b1;
    sb.push_back(model_beat(a, b, 1'b0));
    job_flags = model_flags(a, b);
    @(negedge clk);
    check("join_accept", 128'(in_tready), 128'(1'b1));
    @(posedge clk); #1;
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    @(negedge clk);
    check("latency_c1", 128'(result_tvalid), 128'(1'b0));
    @(negedge clk);
    check("latency_c2", 128'(result_tvalid), 128'(1'b0));
    @(negedge clk);
    check("latency_c3", 128'(result_tvalid), 128'(1'b1));
    @(posedge clk); #1;
    a = {4{16'hC000}}; b = {4{16'h3F00}};
    sb.push_back(model_beat(a, b, 1'b1));
    job_flags = job_flags | model_flags(a, b);
    send_beat(a, b, 1'b0);
    wait_done();

    // 5: zero-length job, then start while busy is ignored.
    start_job(0);
    repeat (3) @(posedge clk);
    #1;
    check("len0_busy", 128'(busy), 128'(1'b0));
    start_job(2);
    for (int i = 1; i <= 2; i++) begin
      for (int l = 0; l < LANES; l++) begin
        a[16*l +: 16] = rand_bf16();
        b[16*l +: 16] = rand_bf16();
      end
      sb.push_back(model_beat(a, b, i == 2));
      job_flags = job_flags | model_flags(a, b);
      if (i == 1) begin
        start = 1'b1; len = LEN_W'(5);
        @(posedge clk); #1;
        start = 1'b0;
      end
      send_beat(a, b, 1'b0);
    end
    wait_done();

    // 6: reset in DRAIN with two beats in flight, then a clean job.
    tready_mode = 2;
    @(posedge clk); #1;
    start_job(2);
    for (int i = 1; i <= 2; i++) begin
      a = {4{16'h3F80}}; b = {4{16'h4000}};
      send_beat(a, b, 1'b0);
    end
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midjob_reset");
    rst = 1'b0;
    sb.delete();
    held_valid = 1'b0;
    pend_done = 1'b0;
    tready_mode = 1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    run_random_job(3, 1'b0);

    // A few more random jobs.
    for (int j = 0; j < 4; j++) run_random_job($urandom_range(1, 6), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
